// File: rtl/alu_pkg.sv
// Shared constants and default-width transaction types for the ALU issue path.
//   ALU_OP_W / ALU_DATA_W : opcode and data widths of the pipelined ALU
//   ALU_OP_NOP            : opcode driven into the ALU on bubble cycles
//   alu_req_t / alu_rsp_t : request and response records at default widths
package alu_pkg;

  localparam int ALU_OP_W   = 2;
  localparam int ALU_DATA_W = 8;
  localparam int ALU_TAG_W  = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = 2'b00;

  typedef struct packed {
    logic [ALU_OP_W-1:0]   opcode;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : write request (ignored when full)
//   pop           : read request (ignored when empty)
//   rdata         : head entry, forced to 0 while empty
//   full, empty   : occupancy flags derived from a registered count
// DEPTH must be a power of 2 and at least 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; pointers and count define validity,
  // and rdata is masked while empty so stale contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end for a non-stallable pipelined ALU.
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready/in_*       : tagged request handshake into the input FIFO
//   alu_opcode/alu_operand_a/_b  : registered stage-0 drive into the ALU
//   alu_result                   : ALU output, ALU_LATENCY edges after alu_* change
//   out_valid/out_ready/out_*    : result handshake from the show-ahead output FIFO
// Issue is gated by a credit pool equal to OUT_DEPTH, so every result in flight
// always has a reserved output FIFO slot.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DATA_W      = ALU_DATA_W,
  parameter int TAG_W       = 4,
  parameter int IN_DEPTH    = 4,
  parameter int OUT_DEPTH   = 4,
  parameter int ALU_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_opcode,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic [ALU_OP_W-1:0] alu_opcode,
  output logic [DATA_W-1:0]   alu_operand_a,
  output logic [DATA_W-1:0]   alu_operand_b,
  input  logic [DATA_W-1:0]   alu_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [TAG_W-1:0]    out_tag
);

  typedef struct packed {
    logic [ALU_OP_W-1:0] opcode;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [TAG_W-1:0]    tag;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  tag;
  } rsp_t;

  localparam int CRED_W = $clog2(OUT_DEPTH) + 1;

  req_t in_wdata, in_head;
  logic in_push, in_full, in_empty, issue;
  rsp_t out_wdata, out_head;
  logic out_push, out_pop, out_full, out_empty;

  logic [ALU_OP_W-1:0]               alu_opcode_q;
  logic [DATA_W-1:0]                 alu_a_q, alu_b_q;
  logic                              s0_valid_q;
  logic [TAG_W-1:0]                  s0_tag_q;
  logic [ALU_LATENCY-1:0]            tag_vld_q;
  logic [ALU_LATENCY-1:0][TAG_W-1:0] tag_q;
  logic [CRED_W-1:0]                 credits_q, credits_d;

  // Input side: in_ready is built from the registered full flag, so a pop in
  // the same cycle never opens a slot for a push.
  assign in_ready = !in_full && !rst;
  assign in_push  = in_valid && in_ready;
  assign in_wdata = '{opcode: in_opcode, a: in_a, b: in_b, tag: in_tag};
  assign issue    = !in_empty && (credits_q != '0);

  sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .pop   (issue),
    .wdata (in_wdata),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty)
  );

  // Result capture: the last tag stage names the owner of this cycle's
  // alu_result. The full guard is redundant under the credit scheme.
  assign out_push  = tag_vld_q[ALU_LATENCY-1] && !out_full;
  assign out_wdata = '{result: alu_result, tag: tag_q[ALU_LATENCY-1]};
  assign out_valid = !out_empty;
  assign out_pop   = out_valid && out_ready;

  sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (out_wdata),
    .rdata (out_head),
    .full  (out_full),
    .empty (out_empty)
  );

  assign out_result    = out_head.result;
  assign out_tag       = out_head.tag;
  assign alu_opcode    = alu_opcode_q;
  assign alu_operand_a = alu_a_q;
  assign alu_operand_b = alu_b_q;

  // A credit leaves on issue and returns when its result is popped downstream.
  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    credits_d = credits_q;
    unique case ({issue, out_pop})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode_q <= ALU_OP_NOP;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      s0_valid_q   <= 1'b0;
      s0_tag_q     <= '0;
      tag_vld_q    <= '0;
      tag_q        <= '0;
      credits_q    <= CRED_W'(OUT_DEPTH);
    end else begin
      if (issue) begin
        alu_opcode_q <= in_head.opcode;
        alu_a_q      <= in_head.a;
        alu_b_q      <= in_head.b;
        s0_valid_q   <= 1'b1;
        s0_tag_q     <= in_head.tag;
      end else begin
        alu_opcode_q <= ALU_OP_NOP;
        alu_a_q      <= '0;
        alu_b_q      <= '0;
        s0_valid_q   <= 1'b0;
        s0_tag_q     <= '0;
      end
      // Tag pipe mirrors the ALU's internal stages one-for-one.
      tag_vld_q[0] <= s0_valid_q;
      tag_q[0]     <= s0_tag_q;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_q[i]     <= tag_q[i-1];
      end
      credits_q <= credits_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a stub pipelined ALU and a response
// scoreboard filled on input handshakes and drained on output handshakes.
module tb_alu_issue_unit;
  import alu_pkg::*;

  localparam int DATA_W    = 8;
  localparam int TAG_W     = 4;
  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;
  localparam int LAT       = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_opcode;
  logic [DATA_W-1:0] in_a, in_b;
  logic [TAG_W-1:0]  in_tag;
  logic [1:0]        alu_opcode;
  logic [DATA_W-1:0] alu_operand_a, alu_operand_b, alu_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;

  int total = 0;
  int bad   = 0;
  int issue_seen = 0;
  bit rand_ready = 0;

  alu_rsp_t sb_q[$];

  always #5 clk = ~clk;

  alu_issue_unit #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .IN_DEPTH(IN_DEPTH),
    .OUT_DEPTH(OUT_DEPTH), .ALU_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_opcode(alu_opcode), .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  function automatic logic [DATA_W-1:0] alu_model(input logic [1:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // Stub ALU: LAT registers, so alu_result follows alu_* by LAT edges.
  logic [DATA_W-1:0] alu_pipe [LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_model(alu_opcode, alu_operand_a, alu_operand_b);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[LAT-1];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
  logic              hold_q = 1'b0;
  logic [DATA_W-1:0] hold_res;
  logic [TAG_W-1:0]  hold_tag;
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      hold_q = 1'b0;
    end else begin
      int inflight;
      if (in_valid && in_ready)
        sb_q.push_back('{result: alu_model(in_opcode, in_a, in_b), tag: in_tag});
      if (hold_q) begin
        check("hold_valid",  out_valid, 1'b1);
        check("hold_result", out_result, hold_res);
        check("hold_tag",    out_tag, hold_tag);
      end
      hold_q   = out_valid && !out_ready;
      hold_res = out_result;
      hold_tag = out_tag;
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          alu_rsp_t exp;
          exp = sb_q.pop_front();
          check("sb_result", out_result, exp.result);
          check("sb_tag",    out_tag, exp.tag);
        end
      end
      inflight = int'(dut.s0_valid_q) + $countones(dut.tag_vld_q);
      check("credit_inv", int'(dut.credits_q) + inflight + int'(dut.u_out_fifo.count_q), OUT_DEPTH);
      check("out_no_ovf", dut.tag_vld_q[LAT-1] && dut.u_out_fifo.full, 1'b0);
      if (alu_operand_a != '0) issue_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic send(input logic [1:0] op, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tag);
    int n = 0;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_tag = tag;
    while (!in_ready && n < 100) begin tick(); n++; end
    check("send_timeout", n < 100, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 300) begin tick(); n++; end
    check("drain_timeout", n < 300, 1'b1);
    check("drain_sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    tick(); tick();

    // 1. reset values, then a single request and its latency
    check("rst_in_ready",   in_ready, 1'b0);
    check("rst_alu_op",     alu_opcode, 2'b00);
    check("rst_alu_a",      alu_operand_a, 0);
    check("rst_alu_b",      alu_operand_b, 0);
    check("rst_out_valid",  out_valid, 1'b0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag",    out_tag, 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_credits",  dut.credits_q, OUT_DEPTH);
    send(2'b00, 8'd5, 8'd3, 4'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("lat_valid_%0d", k), out_valid, (k == 4));
    end
    check("t1_result", out_result, 8'd8);
    check("t1_tag",    out_tag, 4'd1);
    tick();
    check("t1_valid_after_pop", out_valid, 1'b0);
    check("t1_credits", dut.credits_q, OUT_DEPTH);

    // 2. back-to-back requests, results on consecutive cycles
    send(2'b01, 8'd10, 8'd7, 4'd2);
    send(2'b10, 8'd12, 8'd5, 4'd3);
    send(2'b11, 8'd9,  8'd6, 4'd4);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("t2_wait", n < 20, 1'b1);
    check("t2_r0", out_result, 8'd3);  check("t2_g0", out_tag, 4'd2);
    tick();
    check("t2_v1", out_valid, 1'b1);
    check("t2_r1", out_result, 8'd4);  check("t2_g1", out_tag, 4'd3);
    tick();
    check("t2_v2", out_valid, 1'b1);
    check("t2_r2", out_result, 8'd15); check("t2_g2", out_tag, 4'd4);
    tick();
    check("t2_v3", out_valid, 1'b0);

    // 3. stalled consumer: credits cap issue, input FIFO fills
    out_ready = 1'b0;
    issue_seen = 0;
    for (int i = 0; i < 8; i++) send(2'(i), 8'(i + 1), 8'(2 * i), 4'(i + 5));
    repeat (10) tick();
    check("t3_issued",    issue_seen, 4);
    check("t3_in_ready",  in_ready, 1'b0);
    check("t3_bubble_op", alu_opcode, 2'b00);
    check("t3_bubble_a",  alu_operand_a, 0);
    check("t3_bubble_b",  alu_operand_b, 0);
    check("t3_out_valid", out_valid, 1'b1);
    check("t3_credits",   dut.credits_q, 0);
    out_ready = 1'b1;
    send(2'b00, 8'd100, 8'd1, 4'd13);
    send(2'b01, 8'd50,  8'd8, 4'd14);
    drain();

    // 4. random traffic with random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++)
      send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 4'($urandom));
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    // 5. reset with requests in flight and buffered
    for (int i = 0; i < 5; i++) send(2'b00, 8'(20 + i), 8'd1, 4'(i));
    check("t5_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_in_ready",  in_ready, 1'b0);
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_out_res",   out_result, 0);
    check("t5_out_tag",   out_tag, 0);
    check("t5_alu_op",    alu_opcode, 2'b00);
    check("t5_alu_a",     alu_operand_a, 0);
    check("t5_alu_b",     alu_operand_b, 0);
    check("t5_credits",   dut.credits_q, OUT_DEPTH);
    tick(); tick();
    rst = 1'b0;

    // 6. idle input: only bubbles, nothing emerges (stale results would too)
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t6_alu_op",    alu_opcode, 2'b00);
      check("t6_alu_a",     alu_operand_a, 0);
      check("t6_alu_b",     alu_operand_b, 0);
      check("t6_out_valid", out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
